// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result buffer, writeback head and committed flags
//
// Purpose:
//   Two-entry in-order buffer sitting directly after the ALU. Each accepted
//   entry carries a result, its flags, a destination register and two write
//   enables. The head entry is presented to register-file writeback. The
//   architectural flags register is updated only when a flag-writing entry
//   retires. The branch condition is evaluated against those committed flags.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  ALU entry handshake (accept = in_valid & in_ready)
//   in_result          ALU result
//   in_flags           ALU flags {carry, overflow, negative, zero}
//   in_dest            destination register index
//   in_reg_we          entry writes the register file
//   in_flag_we         entry updates flags_q when it retires
//   out_valid/out_ready writeback handshake (retire = out_valid & out_ready)
//   out_result         head result, 0 when empty
//   out_dest           head destination, 0 when empty
//   out_reg_we         head register write enable, 0 when empty
//   flags_q            committed architectural flags
//   br_cond            00 BRE, 01 BRNE, 10 BRG, 11 BRGE
//   br_taken           branch condition evaluated on flags_q
//   occupancy          number of entries held (0..2)

module alu_result_stage #(
  parameter int DATA_W     = 8,
  parameter int FLAG_W     = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic [FLAG_W-1:0]     in_flags,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_reg_we,
  input  logic                  in_flag_we,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_reg_we,
  output logic [FLAG_W-1:0]     flags_q,
  input  logic [1:0]            br_cond,
  output logic                  br_taken,
  output logic [1:0]            occupancy
);

  logic [DATA_W-1:0]     result_mem  [2];
  logic [FLAG_W-1:0]     flags_mem   [2];
  logic [REG_ADDR_W-1:0] dest_mem    [2];
  logic                  reg_we_mem  [2];
  logic                  flag_we_mem [2];

  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] occ_q;

  logic accept;
  logic retire;

  // Handshake readiness depends only on registered occupancy, so a full
  // buffer refuses a new entry even when the head retires that same cycle.
  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign occupancy = occ_q;

  assign out_result = out_valid ? result_mem[rd_ptr] : '0;
  assign out_dest   = out_valid ? dest_mem[rd_ptr]   : '0;
  assign out_reg_we = out_valid ? reg_we_mem[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      occ_q   <= 2'd0;
      flags_q <= '0;
      for (int i = 0; i < 2; i++) begin
        result_mem[i]  <= '0;
        flags_mem[i]   <= '0;
        dest_mem[i]    <= '0;
        reg_we_mem[i]  <= 1'b0;
        flag_we_mem[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        result_mem[wr_ptr]  <= in_result;
        flags_mem[wr_ptr]   <= in_flags;
        dest_mem[wr_ptr]    <= in_dest;
        reg_we_mem[wr_ptr]  <= in_reg_we;
        flag_we_mem[wr_ptr] <= in_flag_we;
        wr_ptr              <= ~wr_ptr;
      end

      if (retire) begin
        rd_ptr <= ~rd_ptr;
        if (flag_we_mem[rd_ptr]) begin
          flags_q <= flags_mem[rd_ptr];
        end
      end

      // Accept and retire together leave the count alone; at occupancy 1
      // the pointer toggles alone move the fresh entry to the head.
      case ({accept, retire})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  logic flag_z;
  logic flag_n;
  logic flag_v;

  assign flag_z = flags_q[0];
  assign flag_n = flags_q[1];
  assign flag_v = flags_q[2];

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      2'b00:   br_taken = flag_z;
      2'b01:   br_taken = ~flag_z;
      2'b10:   br_taken = ~flag_z & ~(flag_n ^ flag_v);
      default: br_taken = ~(flag_n ^ flag_v);
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed scoreboard bench for alu_result_stage

module tb_alu_result_stage;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [3:0] in_flags;
  logic [1:0] in_dest;
  logic       in_reg_we;
  logic       in_flag_we;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [1:0] out_dest;
  logic       out_reg_we;
  logic [3:0] flags_q;
  logic [1:0] br_cond;
  logic       br_taken;
  logic [1:0] occupancy;

  alu_result_stage #(
    .DATA_W(8),
    .FLAG_W(4),
    .REG_ADDR_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_result(in_result),
    .in_flags(in_flags),
    .in_dest(in_dest),
    .in_reg_we(in_reg_we),
    .in_flag_we(in_flag_we),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_dest(out_dest),
    .out_reg_we(out_reg_we),
    .flags_q(flags_q),
    .br_cond(br_cond),
    .br_taken(br_taken),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] fl;
    logic [1:0] d;
    logic       rwe;
    logic       fwe;
  } entry_t;

  entry_t     sb[$];
  logic [3:0] model_flags;
  int         checks;
  int         failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_br(input logic [1:0] c, input logic [3:0] f);
    logic z, n, v;
    z = f[0];
    n = f[1];
    v = f[2];
    case (c)
      2'b00:   return z;
      2'b01:   return ~z;
      2'b10:   return ~z & ~(n ^ v);
      default: return ~(n ^ v);
    endcase
  endfunction

  // Called just after a falling edge with the cycle's inputs already driven.
  task automatic check_outputs();
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, sb.size() != 2);
    chk("occupancy", occupancy, sb.size());
    chk("flags_q", flags_q, model_flags);
    if (sb.size() != 0) begin
      chk("out_result", out_result, sb[0].res);
      chk("out_dest", out_dest, sb[0].d);
      chk("out_reg_we", out_reg_we, sb[0].rwe);
    end else begin
      chk("out_result_idle", out_result, 0);
      chk("out_dest_idle", out_dest, 0);
      chk("out_reg_we_idle", out_reg_we, 0);
    end
    for (int c = 0; c < 4; c++) begin
      br_cond = c[1:0];
      #1;
      chk("br_taken", br_taken, model_br(c[1:0], model_flags));
    end
  endtask

  task automatic step(input logic iv, input logic [7:0] res, input logic [3:0] fl,
                      input logic [1:0] d, input logic rwe, input logic fwe,
                      input logic ordy);
    logic   acc;
    logic   ret;
    entry_t e;
    in_valid   = iv;
    in_result  = res;
    in_flags   = fl;
    in_dest    = d;
    in_reg_we  = rwe;
    in_flag_we = fwe;
    out_ready  = ordy;
    check_outputs();
    acc = iv && (sb.size() != 2);
    ret = ordy && (sb.size() != 0);
    e   = '{res: res, fl: fl, d: d, rwe: rwe, fwe: fwe};
    @(posedge clk);
    if (ret) begin
      entry_t h;
      h = sb.pop_front();
      if (h.fwe) model_flags = h.fl;
    end
    if (acc) sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_result = 8'hEE;
    in_flags  = 4'b1111;
    in_dest   = 2'd3;
    in_reg_we = 1'b1;
    in_flag_we = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    sb.delete();
    model_flags = 4'b0000;
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_flags = 4'b0000;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_result   = 8'h00;
    in_flags    = 4'b0000;
    in_dest     = 2'd0;
    in_reg_we   = 1'b0;
    in_flag_we  = 1'b0;
    out_ready   = 1'b0;
    br_cond     = 2'b00;
    @(negedge clk);
    @(negedge clk);
    apply_reset();

    // Reset then idle
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    step(0, 8'h77, 4'b1010, 2'd1, 1, 1, 1);

    // Single entry: accept, hold, then retire
    step(1, 8'h5A, 4'b0000, 2'd2, 1, 1, 0);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    chk("t2_flags", flags_q, 4'b0000);
    chk("t2_occ", occupancy, 2'd0);

    // Fill to two, third offer refused, then drain in order
    step(1, 8'h01, 4'b1000, 2'd1, 1, 1, 0);
    step(1, 8'h02, 4'b0100, 2'd2, 1, 0, 0);
    step(1, 8'h03, 4'b0010, 2'd3, 1, 1, 0);
    chk("t3_full_ready", in_ready, 1'b0);
    step(1, 8'h03, 4'b0010, 2'd3, 1, 1, 1);
    step(1, 8'h03, 4'b0010, 2'd3, 1, 1, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    chk("t3_flags_after_03", flags_q, 4'b0010);

    // Occupancy 1 with simultaneous accept and retire, repeated
    step(1, 8'h10, 4'b0000, 2'd0, 0, 0, 0);
    step(1, 8'h11, 4'b0001, 2'd1, 1, 1, 1);
    chk("t4_occ", occupancy, 2'd1);
    chk("t4_head", out_result, 8'h11);
    step(1, 8'h12, 4'b1001, 2'd2, 1, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);

    // Flag commit and branch evaluation; non-flag-writing entry keeps flags
    step(1, 8'h20, 4'b0110, 2'd0, 0, 1, 0);
    step(1, 8'h21, 4'b0001, 2'd1, 0, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    chk("t5_flags", flags_q, 4'b0110);
    br_cond = 2'b10; #1; chk("t5_brg", br_taken, 1'b1);
    br_cond = 2'b11; #1; chk("t5_brge", br_taken, 1'b1);
    br_cond = 2'b00; #1; chk("t5_bre", br_taken, 1'b0);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    chk("t5_flags_kept", flags_q, 4'b0110);

    // Reset while full with accept and retire requested
    step(1, 8'h30, 4'b1011, 2'd3, 1, 1, 0);
    step(1, 8'h31, 4'b0101, 2'd2, 1, 1, 0);
    chk("t6_pre_occ", occupancy, 2'd2);
    apply_reset();
    chk("t6_occ", occupancy, 2'd0);
    chk("t6_flags", flags_q, 4'b0000);
    chk("t6_out_valid", out_valid, 1'b0);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 1);

    // After reset the pointers restart cleanly
    step(1, 8'hA5, 4'b0100, 2'd1, 1, 1, 0);
    step(1, 8'hB6, 4'b0010, 2'd2, 0, 1, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 1);
    step(0, 8'h00, 4'b0000, 2'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
